// File: rtl/ppu_timing_gen.sv
// PPU video timing generator: pixel strobe divider, H/V dot and line counters,
// blanking decode, VBlank status flag/interrupt and the NTSC odd-frame dot skip.
module ppu_timing_gen #(
  parameter int CNT_W     = 9,
  parameter int HTOTAL    = 341,
  parameter int HVIS      = 256,
  parameter int VVIS      = 240,
  parameter int VTOT_NTSC = 262,
  parameter int VTOT_PAL  = 312,
  parameter int DIV_NTSC  = 4,
  parameter int DIV_PAL   = 5
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             PAL,
  input  logic             RENDER_EN,
  input  logic             VBL_EN,
  input  logic             RD_STATUS,
  output logic             PCLK_STB,
  output logic [CNT_W-1:0] H,
  output logic [CNT_W-1:0] V,
  output logic             HC,
  output logic             VC,
  output logic             HBLANK,
  output logic             VBLANK,
  output logic             ODD,
  output logic             VBL_FLAG,
  output logic             N_INT
);

  localparam int DIV_MAX = (DIV_PAL > DIV_NTSC) ? DIV_PAL : DIV_NTSC;
  localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST_N = DIV_W'(DIV_NTSC - 1);
  localparam logic [DIV_W-1:0] DIV_LAST_P = DIV_W'(DIV_PAL - 1);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HTOTAL - 1);
  localparam logic [CNT_W-1:0] H_SKIP   = CNT_W'(HTOTAL - 2);
  localparam logic [CNT_W-1:0] H_FLAG   = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(HVIS);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(VVIS);
  localparam logic [CNT_W-1:0] V_SET    = CNT_W'(VVIS + 1);
  localparam logic [CNT_W-1:0] V_PRE_N  = CNT_W'(VTOT_NTSC - 1);
  localparam logic [CNT_W-1:0] V_PRE_P  = CNT_W'(VTOT_PAL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DIV_W-1:0] div_q, div_d, div_last;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d, v_pre;
  logic             mode_q, mode_d;
  logic             hc_q, hc_d, vc_q, vc_d;
  logic             odd_q, odd_d;
  logic             flag_q, flag_d;
  logic             stb, pre_line, skip, eol, flag_set, flag_clr;

  always_comb begin
    div_last = mode_q ? DIV_LAST_P : DIV_LAST_N;
    v_pre    = mode_q ? V_PRE_P : V_PRE_N;
    stb      = (div_q == div_last);
    pre_line = (v_q == v_pre);
    // Odd NTSC frames with rendering on drop the last dot of the pre-render line.
    skip     = !mode_q && odd_q && RENDER_EN && pre_line && (h_q == H_SKIP);
    eol      = (h_q == H_LAST) || skip;
    flag_set = stb && (v_q == V_SET) && (h_q == H_FLAG);
    flag_clr = stb && pre_line && (h_q == H_FLAG);
  end

  always_comb begin
    div_d  = stb ? '0 : div_q + DIV_ONE;
    h_d    = h_q;
    v_d    = v_q;
    hc_d   = hc_q;
    vc_d   = vc_q;
    odd_d  = odd_q;
    mode_d = mode_q;
    if (stb) begin
      hc_d = 1'b0;
      vc_d = 1'b0;
      if (eol) begin
        h_d  = '0;
        hc_d = 1'b1;
        if (pre_line) begin
          v_d    = '0;
          vc_d   = 1'b1;
          odd_d  = ~odd_q;
          mode_d = PAL;
        end else begin
          v_d = v_q + CNT_ONE;
        end
      end else begin
        h_d = h_q + CNT_ONE;
      end
    end
    // A status read wins over a coincident set, so that VBlank goes unflagged.
    flag_d = flag_q;
    if (RD_STATUS || flag_clr) begin
      flag_d = 1'b0;
    end else if (flag_set) begin
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      hc_q   <= 1'b0;
      vc_q   <= 1'b0;
      odd_q  <= 1'b0;
      flag_q <= 1'b0;
      mode_q <= PAL;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      hc_q   <= hc_d;
      vc_q   <= vc_d;
      odd_q  <= odd_d;
      flag_q <= flag_d;
      mode_q <= mode_d;
    end
  end

  assign PCLK_STB = stb;
  assign H        = h_q;
  assign V        = v_q;
  assign HC       = hc_q;
  assign VC       = vc_q;
  assign HBLANK   = (h_q >= H_VIS);
  assign VBLANK   = (v_q >= V_VIS);
  assign ODD      = odd_q;
  assign VBL_FLAG = flag_q;
  assign N_INT    = ~(flag_q & VBL_EN);

endmodule

// File: tb/tb_ppu_timing_gen.sv
// Bench for ppu_timing_gen using a shrunken raster (12 dots x 10/12 lines) so whole
// frames fit in a short run; a frame-position model predicts every output each cycle.
module tb_ppu_timing_gen;

  localparam int CW  = 9;
  localparam int HT  = 12;
  localparam int HV  = 8;
  localparam int VV  = 6;
  localparam int VTN = 10;
  localparam int VTP = 12;
  localparam int DN  = 4;
  localparam int DP  = 5;
  localparam int LIM = 2000;

  logic          CLK = 1'b0;
  logic          RES = 1'b1;
  logic          PAL = 1'b0;
  logic          RENDER_EN = 1'b0;
  logic          VBL_EN = 1'b0;
  logic          RD_STATUS = 1'b0;
  logic          PCLK_STB;
  logic [CW-1:0] H, V;
  logic          HC, VC, HBLANK, VBLANK, ODD, VBL_FLAG, N_INT;

  ppu_timing_gen #(
    .CNT_W(CW), .HTOTAL(HT), .HVIS(HV), .VVIS(VV),
    .VTOT_NTSC(VTN), .VTOT_PAL(VTP), .DIV_NTSC(DN), .DIV_PAL(DP)
  ) dut (
    .CLK(CLK), .RES(RES), .PAL(PAL), .RENDER_EN(RENDER_EN), .VBL_EN(VBL_EN),
    .RD_STATUS(RD_STATUS), .PCLK_STB(PCLK_STB), .H(H), .V(V), .HC(HC), .VC(VC),
    .HBLANK(HBLANK), .VBLANK(VBLANK), .ODD(ODD), .VBL_FLAG(VBL_FLAG), .N_INT(N_INT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: position of the current dot within the frame, plus frame-level state.
  int m_div, m_pos;
  bit m_mode, m_odd, m_flag, m_seen;
  int t_dv, t_vt, t_n, t_nxt;
  bit t_stb;

  always @(posedge CLK) begin
    if (RES) begin
      m_div  <= 0;
      m_pos  <= 0;
      m_odd  <= 1'b0;
      m_flag <= 1'b0;
      m_seen <= 1'b0;
      m_mode <= PAL;
    end else begin
      t_dv  = m_mode ? DP : DN;
      t_vt  = m_mode ? VTP : VTN;
      t_stb = (m_div == t_dv - 1);
      m_div <= t_stb ? 0 : m_div + 1;
      if (t_stb) begin
        t_n   = HT * t_vt;
        t_nxt = m_pos + 1;
        if (t_nxt == t_n || (!m_mode && m_odd && RENDER_EN && t_nxt == t_n - 1)) begin
          t_nxt = 0;
          m_odd  <= ~m_odd;
          m_mode <= PAL;
        end
        m_pos  <= t_nxt;
        m_seen <= 1'b1;
      end
      if (RD_STATUS) m_flag <= 1'b0;
      else if (t_stb && m_pos == (VV + 1) * HT + 1) m_flag <= 1'b1;
      else if (t_stb && m_pos == (t_vt - 1) * HT + 1) m_flag <= 1'b0;
    end
  end

  bit cmp_on = 1'b0;
  always @(negedge CLK) begin
    if (cmp_on) begin
      int eh, ev;
      eh = m_pos % HT;
      ev = m_pos / HT;
      chk("pclk_stb", int'(PCLK_STB), int'(m_div == (m_mode ? DP : DN) - 1));
      chk("h",        int'(H), eh);
      chk("v",        int'(V), ev);
      chk("hc",       int'(HC), int'(m_seen && eh == 0));
      chk("vc",       int'(VC), int'(m_seen && m_pos == 0));
      chk("hblank",   int'(HBLANK), int'(eh >= HV));
      chk("vblank",   int'(VBLANK), int'(ev >= VV));
      chk("odd",      int'(ODD), int'(m_odd));
      chk("vbl_flag", int'(VBL_FLAG), int'(m_flag));
      chk("n_int",    int'(N_INT), int'(!(m_flag && VBL_EN)));
    end
  end

  function automatic bit ev_sel(input int sel);
    case (sel)
      0:       return HC;
      1:       return VC;
      2:       return VBL_FLAG;
      3:       return (V == CW'(8));
      default: return (V == CW'(2));
    endcase
  endfunction

  // Counts CLK edges until the selected condition rises; a missed event counts as a failure.
  task automatic wait_rise(input int sel, input string nm, output int n);
    bit prev, cur, found;
    n = 0;
    found = 1'b0;
    prev = ev_sel(sel);
    while (!found && n < LIM) begin
      @(posedge CLK); #1;
      n++;
      cur = ev_sel(sel);
      if (cur && !prev) found = 1'b1;
      prev = cur;
    end
    if (!found) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic cyc(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    int n1, n2;
    bit hit;
    @(posedge CLK); #1;
    cmp_on = 1'b1;
    cyc(1);
    RES = 1'b0;
    chk("reset_h", int'(H), 0);
    chk("reset_nint", int'(N_INT), 1);

    // NTSC, rendering off: 48 CLK to first line wrap, 480 to first frame wrap.
    wait_rise(0, "first_hc", n1);
    chk("first_hc_cycles", n1, 48);
    wait_rise(1, "first_vc", n2);
    chk("first_vc_cycles", n1 + n2, 480);
    chk("odd_after_vc", int'(ODD), 1);

    // Odd frame with rendering on: one dot shorter; flag rises at V=7 H=1 -> shows H=2.
    RENDER_EN = 1'b1;
    VBL_EN = 1'b1;
    wait_rise(2, "flag_rise", n1);
    chk("flag_rise_cycles", n1, 344);
    chk("flag_rise_v", int'(V), 7);
    chk("flag_rise_h", int'(H), 2);
    chk("flag_rise_nint", int'(N_INT), 0);
    wait_rise(1, "odd_vc", n2);
    chk("odd_frame_cycles", n1 + n2, 476);
    chk("odd_after_odd", int'(ODD), 0);

    // Even frame: status read during VBlank clears the flag next cycle.
    wait_rise(3, "v8", n1);
    RD_STATUS = 1'b1;
    cyc(1);
    RD_STATUS = 1'b0;
    chk("rd_clear_flag", int'(VBL_FLAG), 0);
    chk("rd_clear_nint", int'(N_INT), 1);
    wait_rise(1, "even_vc", n2);
    chk("even_frame_cycles", n1 + n2 + 1, 480);

    // Odd frame: enable toggling while flagged follows immediately.
    wait_rise(2, "flag_rise2", n1);
    VBL_EN = 1'b0;
    #1 chk("en_off_nint", int'(N_INT), 1);
    VBL_EN = 1'b1;
    #1 chk("en_on_nint", int'(N_INT), 0);
    wait_rise(1, "vc3", n2);

    // Read coincident with the set strobe suppresses the flag for the whole VBlank.
    hit = 1'b0;
    for (int i = 0; i < LIM && !hit; i++) begin
      if (PCLK_STB && V == CW'(7) && H == CW'(1)) hit = 1'b1;
      else cyc(1);
    end
    chk("race_found", int'(hit), 1);
    RD_STATUS = 1'b1;
    cyc(1);
    RD_STATUS = 1'b0;
    chk("race_flag", int'(VBL_FLAG), 0);
    chk("race_nint", int'(N_INT), 1);
    wait_rise(1, "vc4", n2);

    // PAL request mid-frame takes effect only from the next frame.
    wait_rise(4, "v2", n1);
    PAL = 1'b1;
    wait_rise(1, "vc5", n2);
    chk("pal_late_v", int'(n1 + n2 < 500), 1);
    wait_rise(1, "pal_vc", n1);
    chk("pal_frame_cycles", n1, 720);

    // Mid-frame reset with the flag set clears everything.
    wait_rise(3, "pal_v8", n1);
    chk("pre_reset_flag", int'(VBL_FLAG), 1);
    PAL = 1'b0;
    RES = 1'b1;
    cyc(1);
    chk("rst_h", int'(H), 0);
    chk("rst_v", int'(V), 0);
    chk("rst_flag", int'(VBL_FLAG), 0);
    chk("rst_nint", int'(N_INT), 1);
    RES = 1'b0;
    wait_rise(0, "post_rst_hc", n1);
    chk("post_rst_hc_cycles", n1, 48);
    cyc(4);

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
